uop_logic_pipe: RTL and testbench

UOP_LOGIC_PIPE -- requirements
Module: uop_logic_pipe

---
 rtl/uop_logic_pipe_if.sv | 31 +++
 rtl/uop_logic_pipe.sv | 89 ++++++++
 tb/tb_uop_logic_pipe.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uop_logic_pipe_if.sv
// Handshake bundle for uop_logic_pipe: operand beat in, result beat out.
// The slave side is the pipe, the master side is its environment.
interface uop_logic_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             red_and;
  logic             red_or;
  logic             red_xor;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y,
    input  red_and, red_or, red_xor, txn_count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y,
    output red_and, red_or, red_xor, txn_count
  );
endinterface

// File: rtl/uop_logic_pipe.sv
// Two-stage bitwise logic pipe with valid/ready handshake,
// result reductions and a delivered-beat counter.
module uop_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  uop_logic_pipe_if.slave bus
);
  logic [WIDTH-1:0] w_res;
  logic             w_s2_free;
  logic             w_accept;
  logic             w_deliver;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_and;
  logic             r_or;
  logic             r_xor;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_res = bus.a;
    case (bus.op)
      3'b000:  w_res = bus.a & bus.b;
      3'b001:  w_res = bus.a | bus.b;
      3'b010:  w_res = bus.a ^ bus.b;
      3'b011:  w_res = ~(bus.a ^ bus.b);
      3'b100:  w_res = ~(bus.a & bus.b);
      3'b101:  w_res = ~(bus.a | bus.b);
      3'b110:  w_res = ~bus.a;
      default: w_res = bus.a;
    endcase
  end

  // Ready depends only on state and out_ready, never on in_valid.
  assign w_s2_free = !r_s2_valid || bus.out_ready;
  assign bus.in_ready = !r_s1_valid || w_s2_free;
  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_deliver = r_s2_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1       <= w_res;
    end else if (r_s1_valid && w_s2_free) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_and      <= 1'b0;
      r_or       <= 1'b0;
      r_xor      <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y   <= r_s1;
        r_and <= &r_s1;
        r_or  <= |r_s1;
        r_xor <= ^r_s1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.y         = r_y;
  assign bus.red_and   = r_and;
  assign bus.red_or    = r_or;
  assign bus.red_xor   = r_xor;
  assign bus.txn_count = r_cnt;
endmodule

// File: tb/tb_uop_logic_pipe.sv
// Directed bench for uop_logic_pipe (WIDTH=8, CNT_W=4 so the
// counter wrap is reachable in a few dozen cycles).
module tb_uop_logic_pipe;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  uop_logic_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  uop_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    rst_n         = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    rst_n         = 1'b0;
    #3;
    vectors++;
    if ({bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor}
        !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outs: got v=%b y=%h r=%b%b%b want zeros",
               bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor);
    end
    vectors++;
    if (bus.txn_count !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %h want 0", bus.txn_count);
    end
    step();
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got rdy=%b v=%b want rdy=1 v=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.a = 8'hF0; bus.b = 8'h3C; bus.op = 3'b011;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: out_valid=%b want 0", bus.out_valid);
    end
    step();
    vectors++;
    if ({bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor}
        !== {1'b1, 8'h33, 3'b010}) begin
      miscompares++;
      $display("FAIL single_y: got v=%b y=%h r=%b%b%b want v=1 y=33 r=010",
               bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor);
    end
    step();
    vectors++;
    if (bus.txn_count !== 4'h1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_cnt: got cnt=%h v=%b want cnt=1 v=0",
               bus.txn_count, bus.out_valid);
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp [8];
    int k;
    int first;
    int last;
    exp = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'h0F, 8'hF0};
    k = 0; first = -1; last = -1;
    do_reset();
    bus.a = 8'hF0; bus.b = 8'h3C;
    for (int c = 0; c < 14; c++) begin
      if (bus.out_valid && k < 8) begin
        vectors++;
        if (bus.y !== exp[k]) begin
          miscompares++;
          $display("FAIL sweep_y%0d: got %h want %h", k, bus.y, exp[k]);
        end
        if (first < 0) first = c;
        last = c;
        k++;
      end
      bus.in_valid = (c < 8);
      bus.op = 3'(c);
      step();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (k != 8 || last - first != 7) begin
      miscompares++;
      $display("FAIL sweep_rate: got %0d beats over %0d cycles want 8 over 7",
               k, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3];
    int k;
    logic acc;
    exp = '{8'h30, 8'hFC, 8'hCC};
    k = 0;
    do_reset();
    bus.out_ready = 1'b0;
    bus.a = 8'hF0; bus.b = 8'h3C;
    bus.op = 3'b000; bus.in_valid = 1'b1;
    step();
    bus.op = 3'b001;
    step();
    bus.op = 3'b010;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_third_ready: got %b want 0", bus.in_ready);
    end
    step();
    step();
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.y} !== {2'b01, 8'h30}) begin
      miscompares++;
      $display("FAIL bp_hold: got rdy=%b v=%b y=%h want rdy=0 v=1 y=30",
               bus.in_ready, bus.out_valid, bus.y);
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        vectors++;
        if (k > 2 || bus.y !== exp[k % 3]) begin
          miscompares++;
          $display("FAIL bp_order%0d: got %h want %h", k, bus.y, exp[k % 3]);
        end
        k++;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    vectors++;
    if (k != 3 || bus.txn_count !== 4'h3) begin
      miscompares++;
      $display("FAIL bp_count: got beats=%0d cnt=%h want 3 and 3",
               k, bus.txn_count);
    end
  endtask

  task automatic test_reductions();
    do_reset();
    bus.a = 8'hFF; bus.b = 8'hFF;
    bus.op = 3'b000; bus.in_valid = 1'b1;
    step();
    bus.op = 3'b010;
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor}
        !== {1'b1, 8'hFF, 3'b110}) begin
      miscompares++;
      $display("FAIL red_ones: got v=%b y=%h r=%b%b%b want v=1 y=FF r=110",
               bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor);
    end
    step();
    vectors++;
    if ({bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor}
        !== {1'b1, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL red_zero: got v=%b y=%h r=%b%b%b want v=1 y=00 r=000",
               bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor);
    end
  endtask

  task automatic test_count_wrap();
    int sent;
    int got;
    logic dlv;
    sent = 0; got = 0;
    do_reset();
    bus.a = 8'h5A; bus.b = 8'h0F; bus.op = 3'b001;
    for (int c = 0; c < 40 && got < 17; c++) begin
      bus.in_valid = (sent < 17);
      if (bus.in_valid && bus.in_ready) sent++;
      dlv = bus.out_valid && bus.out_ready;
      step();
      if (dlv) begin
        got++;
        if (got == 15 || got == 16 || got == 17) begin
          vectors++;
          if (bus.txn_count !== 4'((got == 15) ? 15 : got - 16)) begin
            miscompares++;
            $display("FAIL wrap_after_%0d: got %h want %h", got,
                     bus.txn_count, 4'((got == 15) ? 15 : got - 16));
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (got != 17) begin
      miscompares++;
      $display("FAIL wrap_beats: got %0d want 17", got);
    end
  endtask

  task automatic test_reset_midstream();
    int late;
    late = 0;
    do_reset();
    bus.a = 8'hA5; bus.b = 8'h00; bus.op = 3'b111;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.y, bus.txn_count}
        !== {2'b10, 8'hA5, 4'h1}) begin
      miscompares++;
      $display("FAIL mid_full: got v=%b rdy=%b y=%h cnt=%h want 1 0 A5 1",
               bus.out_valid, bus.in_ready, bus.y, bus.txn_count);
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.y, bus.red_and, bus.red_or, bus.red_xor,
         bus.txn_count} !== 16'h0000 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_async: got v=%b y=%h r=%b%b%b cnt=%h rdy=%b",
               bus.out_valid, bus.y, bus.red_and, bus.red_or,
               bus.red_xor, bus.txn_count, bus.in_ready);
    end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.out_valid !== 1'b0) late++;
    end
    vectors++;
    if (late != 0 || bus.txn_count !== 4'h0) begin
      miscompares++;
      $display("FAIL mid_after: got %0d valid cycles cnt=%h want 0 and 0",
               late, bus.txn_count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_op_sweep();
    test_backpressure();
    test_reductions();
    test_count_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
